// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one INCR/FIXED burst at a time from a single-port synchronous SRAM.
// Optional feature macro: AXI_SLV_RAND_DELAY_EN inserts LFSR-driven handshake stalls.
module axi_sram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t            state_r;
    logic [3:0]        id_r;
    logic [MEM_AW-1:0] addr_r;
    logic [7:0]        len_r;
    logic [7:0]        cnt_r;
    logic [1:0]        burst_r;
    logic [2:0]        size_r;
    logic              wlast_err_r;
    logic [3:0]        rid_r;
    logic [1:0]        rresp_r;
    logic              rlast_r;
    logic [3:0]        bid_r;
    logic [1:0]        bresp_r;

    logic              accept_ok_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              aw_acc_s;
    logic              ar_acc_s;
    logic              wbeat_s;
    logic              last_beat_s;
    logic              wr_err_next_s;
    logic              unused_s;

    // FIXED keeps the word address; INCR, WRAP and reserved encodings step it.
    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                    input logic [1:0] burst);
        next_addr = (burst == 2'b00) ? a : a + {{(MEM_AW-1){1'b0}}, 1'b1};
    endfunction

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr_r;

    // Free-running stall generator, taps 16,14,13,11.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign accept_ok_s = lfsr_r[0];
    assign wr_ok_s     = lfsr_r[1];
    assign rd_ok_s     = lfsr_r[2];
`else
    assign accept_ok_s = 1'b1;
    assign wr_ok_s     = 1'b1;
    assign rd_ok_s     = 1'b1;
`endif

    assign unused_s = ^{wid, araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

    // Handshake decodes and the SRAM port; writes hit the SRAM in the W beat cycle.
    always_comb begin
        aw_acc_s      = (state_r == IDLE) && awvalid && accept_ok_s;
        ar_acc_s      = (state_r == IDLE) && !awvalid && arvalid && accept_ok_s;
        wready        = (state_r == WR_DATA) && wr_ok_s;
        wbeat_s       = wready && wvalid;
        last_beat_s   = (cnt_r == len_r);
        wr_err_next_s = wlast_err_r | (wlast != last_beat_s);
        arready       = ar_acc_s;
        awready       = aw_acc_s;
        rvalid        = (state_r == RD_DATA);
        bvalid        = (state_r == WR_RESP);
        ram_addr      = addr_r;
        if (wbeat_s) begin
            ram_en    = 1'b1;
            ram_we    = wstrb;
            ram_wdata = wdata;
        end else begin
            ram_en    = (state_r == RD_REQ) && rd_ok_s;
            ram_we    = 4'b0000;
            ram_wdata = 32'h0000_0000;
        end
        if (rvalid) begin
            rdata = ram_rdata;
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign rid   = rid_r;
    assign rresp = rresp_r;
    assign rlast = rlast_r;
    assign bid   = bid_r;
    assign bresp = bresp_r;

    // Transaction sequencer; response payload registers change only on state transitions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= IDLE;
            id_r        <= 4'd0;
            addr_r      <= '0;
            len_r       <= 8'd0;
            cnt_r       <= 8'd0;
            burst_r     <= 2'b00;
            size_r      <= 3'd0;
            wlast_err_r <= 1'b0;
            rid_r       <= 4'd0;
            rresp_r     <= 2'b00;
            rlast_r     <= 1'b0;
            bid_r       <= 4'd0;
            bresp_r     <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r       <= 8'd0;
                    wlast_err_r <= 1'b0;
                    if (aw_acc_s) begin
                        id_r    <= awid;
                        addr_r  <= awaddr[MEM_AW+1:2];
                        len_r   <= awlen;
                        burst_r <= awburst;
                        size_r  <= awsize;
                        state_r <= WR_DATA;
                    end else if (ar_acc_s) begin
                        id_r    <= arid;
                        addr_r  <= araddr[MEM_AW+1:2];
                        len_r   <= arlen;
                        burst_r <= arburst;
                        size_r  <= arsize;
                        state_r <= RD_REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (rd_ok_s) begin
                        rid_r   <= id_r;
                        rlast_r <= last_beat_s;
                        rresp_r <= (size_r > 3'd2) ? 2'b10 : 2'b00;
                        state_r <= RD_DATA;
                    end else begin
                        state_r <= RD_REQ;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        if (rlast_r) begin
                            state_r <= IDLE;
                        end else begin
                            cnt_r   <= cnt_r + 8'd1;
                            addr_r  <= next_addr(addr_r, burst_r);
                            state_r <= RD_REQ;
                        end
                    end else begin
                        state_r <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (wbeat_s) begin
                        cnt_r       <= cnt_r + 8'd1;
                        addr_r      <= next_addr(addr_r, burst_r);
                        wlast_err_r <= wr_err_next_s;
                        if (last_beat_s) begin
                            bid_r   <= id_r;
                            bresp_r <= (wr_err_next_s || (size_r > 3'd2)) ? 2'b10 : 2'b00;
                            state_r <= WR_RESP;
                        end else begin
                            state_r <= WR_DATA;
                        end
                    end else begin
                        state_r <= WR_DATA;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and randomized bench for axi_sram_slave with a transaction-level memory model.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata, ram_wdata, ram_rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb, ram_we;
    logic        ram_en;
    logic [9:0]  ram_addr;

    logic [31:0] sram [0:1023];
    logic [31:0] mdl  [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_AW(10)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // SRAM fixture: 1-cycle read latency, output held while disabled.
    always @(posedge aclk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= sram[ram_addr];
            end
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] step(input logic [9:0] w, input logic [1:0] burst);
        return (burst == 2'b00) ? w : w + 10'd1;
    endfunction

    task automatic wait_sig(input string tag, ref logic sig);
        int n;
        n = 0;
        while (sig !== 1'b1 && n < 60) begin
            @(negedge aclk); #1;
            n++;
        end
        check(tag, {31'd0, sig}, 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int stall_beat, input int stall_cyc);
        logic [9:0]  w;
        logic [31:0] held;
        int n;
        w = addr[11:2];
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        #1;
        wait_sig("arready", arready);
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        #1;
        check("rd_lat_req", {30'd0, rvalid, ram_en}, 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < 60) begin
                @(negedge aclk); #1;
                n++;
            end
            if (b == 0) check("rd_lat_valid", n, 1);
            check("rvalid", {31'd0, rvalid}, 32'd1);
            check("rdata", rdata, mdl[w]);
            check("rid", {28'd0, rid}, {28'd0, id});
            check("rlast", {31'd0, rlast}, (b == int'(len)) ? 32'd1 : 32'd0);
            check("rresp", {30'd0, rresp}, (size > 3'd2) ? 32'd2 : 32'd0);
            if (b == stall_beat) begin
                held = rdata;
                repeat (stall_cyc) begin
                    @(negedge aclk); #1;
                    check("rdata_hold", rdata, held);
                    check("rvalid_hold", {31'd0, rvalid}, 32'd1);
                end
            end
            rready = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            rready = 1'b0;
            #1;
            w = step(w, burst);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int bad_beat,
                            input logic use_fixed, input logic [31:0] fdata, input logic [3:0] fstrb);
        logic [9:0]  w;
        logic [31:0] d;
        logic [3:0]  s;
        logic        err;
        w = addr[11:2];
        err = 1'b0;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        #1;
        wait_sig("awready", awready);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = use_fixed ? fdata : $urandom;
            s = use_fixed ? fstrb : 4'($urandom_range(0, 15));
            wdata = d; wstrb = s; wid = 4'($urandom_range(0, 15));
            wlast = (b == int'(len)) ^ (b == bad_beat);
            if (b == bad_beat) err = 1'b1;
            wvalid = 1'b1;
            #1;
            wait_sig("wready", wready);
            check("ram_en_we", {27'd0, ram_en, ram_we}, {27'd0, 1'b1, s});
            check("ram_addr", {22'd0, ram_addr}, {22'd0, w});
            for (int k = 0; k < 4; k++) begin
                if (s[k]) mdl[w][8*k +: 8] = d[8*k +: 8];
            end
            @(posedge aclk);
            @(negedge aclk);
            w = step(w, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        wait_sig("bvalid", bvalid);
        check("bid", {28'd0, bid}, {28'd0, id});
        check("bresp", {30'd0, bresp}, (err || size > 3'd2) ? 32'd2 : 32'd0);
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bt;
        for (int i = 0; i < 1024; i++) begin
            sram[i] = $urandom;
            mdl[i]  = sram[i];
        end
        sram[16] = 32'h12345678; mdl[16] = 32'h12345678;
        sram[32] = 32'hFFFFFFFF; mdl[32] = 32'hFFFFFFFF;
        ram_rdata = 32'd0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("reset_ctl", {25'd0, arready, awready, wready, rvalid, bvalid, rlast, ram_en}, 32'd0);
        check("reset_pay", {16'd0, rid, bid, rresp, bresp, ram_we}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        do_read(4'd3, 32'h40, 8'd0, 2'b01, 3'd2, -1, 0);
        do_read(4'd6, 32'h100, 8'd3, 2'b01, 3'd2, 1, 3);
        do_write(4'd9, 32'h80, 8'd0, 2'b01, 3'd2, -1, 1'b1, 32'hAABBCCDD, 4'b0011);
        check("strobe_merge_model", mdl[32], 32'hFFFFCCDD);
        do_read(4'd1, 32'h80, 8'd0, 2'b01, 3'd2, -1, 0);
        do_read(4'd2, 32'h44, 8'd0, 2'b01, 3'd3, -1, 0);

        // Simultaneous AW and AR: write wins, read follows once back in IDLE.
        @(negedge aclk);
        awid = 4'd7; awaddr = 32'h48; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
        arid = 4'd5; araddr = 32'h48; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
        #1;
        check("both_awready", {30'd0, awready, arready}, 32'd2);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        wdata = 32'h0BADCAFE; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        mdl[18] = 32'h0BADCAFE;
        #1;
        check("both_ar_wait", {31'd0, arready}, 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        check("both_bvalid", {31'd0, bvalid}, 32'd1);
        check("both_bid", {28'd0, bid}, 32'd7);
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        #1;
        check("both_arready", {31'd0, arready}, 32'd1);
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        #1;
        wait_sig("both_rvalid", rvalid);
        check("both_rdata", rdata, mdl[18]);
        check("both_rid", {28'd0, rid}, 32'd5);
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;

        do_write(4'd4, 32'hFFC, 8'd1, 2'b01, 3'd2, -1, 1'b0, 32'd0, 4'd0);
        do_read(4'd4, 32'hFFC, 8'd1, 2'b01, 3'd2, -1, 0);
        do_write(4'd8, 32'h300, 8'd2, 2'b01, 3'd2, 1, 1'b0, 32'd0, 4'd0);

        // Reset in the middle of beat 2 of a 4-beat read.
        @(negedge aclk);
        arid = 4'd10; araddr = 32'h200; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        #1;
        wait_sig("rst_beat1", rvalid);
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
        #1;
        wait_sig("rst_beat2", rvalid);
        aresetn = 1'b0;
        #1;
        check("midrst_ctl", {25'd0, arready, awready, wready, rvalid, bvalid, rlast, ram_en}, 32'd0);
        check("midrst_pay", {16'd0, rid, bid, rresp, bresp, ram_we}, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        do_read(4'd11, 32'h40, 8'd0, 2'b01, 3'd2, -1, 0);

        // Randomized bursts checked against the model.
        for (int t = 0; t < 25; t++) begin
            a  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            l  = 8'($urandom_range(0, 15));
            bt = 2'($urandom_range(0, 3));
            do_write(4'($urandom_range(0, 15)), a, l, bt, 3'($urandom_range(0, 2)), -1,
                     1'b0, 32'd0, 4'd0);
            do_read(4'($urandom_range(0, 15)), a, l, bt, 3'd2, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
